// File: rtl/pulse_generator_if.sv
// Configuration/strobe bundle between a pulse_generator and whatever drives it.
// The master side programs timing and run control; the slave side reports the generated waveform.
interface pulse_generator_if #(
   parameter int K_CNTWIDTH   = 16,
   parameter int K_PRESCWIDTH = 8
) ();

   logic                    i_en;
   logic                    i_oneshot;
   logic [K_PRESCWIDTH-1:0] i_presc;
   logic [K_CNTWIDTH-1:0]   i_period;
   logic [K_CNTWIDTH-1:0]   i_width;
   logic                    i_load;

   logic                    o_pulse;
   logic                    o_rise;
   logic                    o_fall;
   logic                    o_period_end;
   logic                    o_busy;
   logic [K_CNTWIDTH-1:0]   o_cnt;

   modport master (
      output i_en, i_oneshot, i_presc, i_period, i_width, i_load,
      input  o_pulse, o_rise, o_fall, o_period_end, o_busy, o_cnt
   );

   modport slave (
      input  i_en, i_oneshot, i_presc, i_period, i_width, i_load,
      output o_pulse, o_rise, o_fall, o_period_end, o_busy, o_cnt
   );

endinterface

// File: rtl/pulse_generator.sv
// Periodic PWM/servo-style pulse generator with prescaled ticks and double-buffered configuration.
// Shadow registers only change at period boundaries, so a pulse in flight is never truncated.
module pulse_generator #(
   parameter int K_CNTWIDTH   = 16,
   parameter int K_PRESCWIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   pulse_generator_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                  state;
   logic [K_PRESCWIDTH-1:0] presc_sh;
   logic [K_PRESCWIDTH-1:0] presc_cnt;
   logic [K_CNTWIDTH-1:0]   period_sh;
   logic [K_CNTWIDTH-1:0]   width_sh;
   logic [K_CNTWIDTH-1:0]   cnt;
   logic                    oneshot_sh;
   logic                    pending;
   logic                    pulse;
   logic                    rise;
   logic                    fall;
   logic                    period_end;
   logic                    busy;

   logic                    tick;
   logic                    wrap;
   logic                    reload;
   logic                    inc_high;
   logic                    restart_high;
   logic [K_CNTWIDTH-1:0]   cnt_inc;

   // Next-pulse levels are precomputed so o_pulse lands on the same edge as o_cnt.
   assign tick         = (presc_cnt == presc_sh);
   assign wrap         = tick && (cnt == period_sh);
   assign cnt_inc      = cnt + 1'b1;
   assign inc_high     = (cnt_inc < width_sh);
   assign reload       = pending || bus.i_load;
   assign restart_high = reload ? (bus.i_width != '0) : (width_sh != '0);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         presc_sh   <= '0;
         presc_cnt  <= '0;
         period_sh  <= '0;
         width_sh   <= '0;
         cnt        <= '0;
         oneshot_sh <= 1'b0;
         pending    <= 1'b0;
         pulse      <= 1'b0;
         rise       <= 1'b0;
         fall       <= 1'b0;
         period_end <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rise       <= 1'b0;
         fall       <= 1'b0;
         period_end <= 1'b0;
         case (state)
            IDLE: begin
               cnt   <= '0;
               pulse <= 1'b0;
               busy  <= 1'b0;
               if (bus.i_en) begin
                  state      <= RUN;
                  busy       <= 1'b1;
                  presc_sh   <= bus.i_presc;
                  period_sh  <= bus.i_period;
                  width_sh   <= bus.i_width;
                  oneshot_sh <= bus.i_oneshot;
                  pending    <= 1'b0;
                  presc_cnt  <= '0;
                  pulse      <= (bus.i_width != '0);
                  rise       <= (bus.i_width != '0);
               end
            end

            RUN: begin
               presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
               if (wrap) begin
                  period_end <= 1'b1;
                  cnt        <= '0;
                  pending    <= 1'b0;
                  if (oneshot_sh || !bus.i_en) begin
                     // Leaving RUN: a high pulse (width > period) still gets its falling strobe.
                     state     <= oneshot_sh ? DONE : IDLE;
                     busy      <= 1'b0;
                     pulse     <= 1'b0;
                     fall      <= pulse;
                     presc_cnt <= '0;
                  end else begin
                     pulse <= restart_high;
                     rise  <= restart_high && !pulse;
                     fall  <= !restart_high && pulse;
                     if (reload) begin
                        presc_sh   <= bus.i_presc;
                        period_sh  <= bus.i_period;
                        width_sh   <= bus.i_width;
                        oneshot_sh <= bus.i_oneshot;
                     end
                  end
               end else begin
                  if (bus.i_load) begin
                     pending <= 1'b1;
                  end
                  if (tick) begin
                     cnt   <= cnt_inc;
                     pulse <= inc_high;
                     rise  <= inc_high && !pulse;
                     fall  <= !inc_high && pulse;
                  end
               end
            end

            DONE: begin
               // Hold here until run request drops so one-shot cannot retrigger.
               cnt   <= '0;
               pulse <= 1'b0;
               busy  <= 1'b0;
               if (!bus.i_en) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.o_pulse      = pulse;
   assign bus.o_rise       = rise;
   assign bus.o_fall       = fall;
   assign bus.o_period_end = period_end;
   assign bus.o_busy       = busy;
   assign bus.o_cnt        = cnt;

endmodule

// File: tb/tb_pulse_generator.sv
// Bench for pulse_generator: a time-offset model predicts every output each cycle,
// and directed scenarios pin pulse lengths and strobe counts to hand-computed values.
module tb_pulse_generator;

   localparam int K_CNTWIDTH   = 16;
   localparam int K_PRESCWIDTH = 8;

   logic i_clk;
   logic i_rst_n;

   pulse_generator_if #(.K_CNTWIDTH(K_CNTWIDTH), .K_PRESCWIDTH(K_PRESCWIDTH)) bus ();

   pulse_generator #(.K_CNTWIDTH(K_CNTWIDTH), .K_PRESCWIDTH(K_PRESCWIDTH)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   int num_compared   = 0;
   int num_mismatched = 0;

   int high_cnt = 0;
   int end_cnt  = 0;
   int rise_cnt = 0;
   int fall_cnt = 0;
   int max_cnt  = 0;

   // Model: elapsed clocks within the current period plus the active configuration.
   typedef enum {M_IDLE, M_RUN, M_DONE} model_mode_t;
   model_mode_t m_mode = M_IDLE;
   int m_t    = 0;
   int m_s    = 0;
   int m_p    = 0;
   int m_w    = 0;
   int m_one  = 0;
   int m_pend = 0;
   int exp_pulse = 0;
   int exp_rise  = 0;
   int exp_fall  = 0;
   int exp_end   = 0;
   int exp_busy  = 0;
   int exp_cnt   = 0;

   task automatic checkOutput(input string name, input int actual, input int expected);
      num_compared++;
      if (actual != expected) begin
         num_mismatched++;
         $display("[TB] FAIL %s: actual %0d, expected %0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   task automatic captureConfig();
      m_s   = int'(bus.i_presc);
      m_p   = int'(bus.i_period);
      m_w   = int'(bus.i_width);
      m_one = int'(bus.i_oneshot);
   endtask

   task automatic modelStep();
      int prev_pulse;
      int period_clocks;
      int high_clocks;
      prev_pulse = exp_pulse;
      exp_end    = 0;
      case (m_mode)
         M_IDLE: begin
            if (bus.i_en) begin
               captureConfig();
               m_pend = 0;
               m_t    = 0;
               m_mode = M_RUN;
            end
         end
         M_RUN: begin
            period_clocks = (m_p + 1) * (m_s + 1);
            if (m_t == period_clocks - 1) begin
               exp_end = 1;
               if (m_one != 0) begin
                  m_mode = M_DONE;
               end else if (!bus.i_en) begin
                  m_mode = M_IDLE;
               end else begin
                  m_t = 0;
                  if (m_pend != 0 || bus.i_load) captureConfig();
                  m_pend = 0;
               end
            end else begin
               m_t++;
               if (bus.i_load) m_pend = 1;
            end
         end
         default: begin
            if (!bus.i_en) m_mode = M_IDLE;
         end
      endcase
      high_clocks = ((m_w < m_p + 1) ? m_w : m_p + 1) * (m_s + 1);
      exp_busy  = (m_mode == M_RUN) ? 1 : 0;
      exp_cnt   = (m_mode == M_RUN) ? m_t / (m_s + 1) : 0;
      exp_pulse = (m_mode == M_RUN && m_t < high_clocks) ? 1 : 0;
      exp_rise  = (exp_pulse == 1 && prev_pulse == 0) ? 1 : 0;
      exp_fall  = (exp_pulse == 0 && prev_pulse == 1) ? 1 : 0;
   endtask

   initial begin
      forever begin
         @(posedge i_clk or negedge i_rst_n);
         if (!i_rst_n) begin
            m_mode = M_IDLE;
            m_t = 0; m_s = 0; m_p = 0; m_w = 0; m_one = 0; m_pend = 0;
            exp_pulse = 0; exp_rise = 0; exp_fall = 0;
            exp_end = 0; exp_busy = 0; exp_cnt = 0;
         end else begin
            modelStep();
         end
      end
   end

   // Every-cycle comparison against the model, sampled mid-cycle.
   initial begin
      forever begin
         @(negedge i_clk);
         if (i_rst_n) begin
            checkOutput("o_pulse", int'(bus.o_pulse), exp_pulse);
            checkOutput("o_rise", int'(bus.o_rise), exp_rise);
            checkOutput("o_fall", int'(bus.o_fall), exp_fall);
            checkOutput("o_period_end", int'(bus.o_period_end), exp_end);
            checkOutput("o_busy", int'(bus.o_busy), exp_busy);
            checkOutput("o_cnt", int'(bus.o_cnt), exp_cnt);
            high_cnt += int'(bus.o_pulse);
            end_cnt  += int'(bus.o_period_end);
            rise_cnt += int'(bus.o_rise);
            fall_cnt += int'(bus.o_fall);
            if (int'(bus.o_cnt) > max_cnt) max_cnt = int'(bus.o_cnt);
         end
      end
   end

   task automatic step();
      @(negedge i_clk);
      #1;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic clearCounters();
      high_cnt = 0; end_cnt = 0; rise_cnt = 0; fall_cnt = 0; max_cnt = 0;
   endtask

   task automatic applyStimulus(input logic en, input logic oneshot, input int presc,
                                input int period, input int width);
      bus.i_en      = en;
      bus.i_oneshot = oneshot;
      bus.i_presc   = K_PRESCWIDTH'(presc);
      bus.i_period  = K_CNTWIDTH'(period);
      bus.i_width   = K_CNTWIDTH'(width);
      bus.i_load    = 1'b0;
   endtask

   task automatic waitCnt(input int target);
      bit found = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge i_clk);
         if (int'(bus.o_cnt) == target) begin
            found = 1;
            break;
         end
      end
      #1;
      if (!found) checkOutput("wait_cnt_timeout", 0, 1);
   endtask

   task automatic waitEnd(output int cycles);
      bit found = 0;
      cycles = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge i_clk);
         cycles++;
         if (bus.o_period_end) begin
            found = 1;
            break;
         end
      end
      #1;
      if (!found) checkOutput("wait_end_timeout", 0, 1);
   endtask

   task automatic waitIdle();
      bit found = 0;
      for (int i = 0; i < 500; i++) begin
         @(negedge i_clk);
         if (!bus.o_busy) begin
            found = 1;
            break;
         end
      end
      #1;
      if (!found) checkOutput("wait_idle_timeout", 0, 1);
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_pulse"}, int'(bus.o_pulse), 0);
      checkOutput({tag, "_rise"}, int'(bus.o_rise), 0);
      checkOutput({tag, "_fall"}, int'(bus.o_fall), 0);
      checkOutput({tag, "_end"}, int'(bus.o_period_end), 0);
      checkOutput({tag, "_busy"}, int'(bus.o_busy), 0);
      checkOutput({tag, "_cnt"}, int'(bus.o_cnt), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, actual running, expected done");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int cycles;
      i_rst_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 0, 0, 0);
      #2;
      i_rst_n = 1'b0;
      #1;
      checkAllZero("reset");
      runCycles(2);
      i_rst_n = 1'b1;
      runCycles(2);

      $display("[TB] continuous presc=0 period=9 width=3");
      applyStimulus(1'b1, 1'b0, 0, 9, 3);
      clearCounters();
      runCycles(30);
      checkOutput("t1_high", high_cnt, 9);
      checkOutput("t1_ends", end_cnt, 2);
      checkOutput("t1_rises", rise_cnt, 3);
      checkOutput("t1_falls", fall_cnt, 3);
      bus.i_en = 1'b0;
      waitIdle();

      $display("[TB] prescaled presc=1 period=9 width=3");
      applyStimulus(1'b1, 1'b0, 1, 9, 3);
      clearCounters();
      runCycles(40);
      checkOutput("t2_high", high_cnt, 12);
      checkOutput("t2_ends", end_cnt, 1);
      checkOutput("t2_maxcnt", max_cnt, 9);
      bus.i_en = 1'b0;
      waitIdle();

      $display("[TB] shadow load of width 3 -> 5");
      applyStimulus(1'b1, 1'b0, 0, 9, 3);
      waitCnt(1);
      bus.i_width = 16'd5;
      bus.i_load  = 1'b1;
      clearCounters();
      step();
      bus.i_load = 1'b0;
      waitEnd(cycles);
      checkOutput("t3_current_high", high_cnt, 2);
      clearCounters();
      runCycles(10);
      checkOutput("t3_next_high", high_cnt, 5);
      bus.i_width = 16'd7;
      waitEnd(cycles);
      clearCounters();
      runCycles(10);
      checkOutput("t3_noload_high", high_cnt, 5);
      bus.i_en = 1'b0;
      waitIdle();

      $display("[TB] width=0 and width>period");
      applyStimulus(1'b1, 1'b0, 0, 9, 0);
      clearCounters();
      runCycles(30);
      checkOutput("t4_w0_high", high_cnt, 0);
      checkOutput("t4_w0_rises", rise_cnt, 0);
      checkOutput("t4_w0_ends", end_cnt, 2);
      bus.i_en = 1'b0;
      waitIdle();
      applyStimulus(1'b1, 1'b0, 0, 9, 12);
      clearCounters();
      runCycles(30);
      checkOutput("t4_w12_high", high_cnt, 30);
      checkOutput("t4_w12_rises", rise_cnt, 1);
      checkOutput("t4_w12_falls", fall_cnt, 0);
      checkOutput("t4_w12_ends", end_cnt, 2);
      bus.i_en = 1'b0;
      waitIdle();

      $display("[TB] one-shot period=4 width=2");
      applyStimulus(1'b1, 1'b1, 0, 4, 2);
      clearCounters();
      runCycles(30);
      checkOutput("t5_high", high_cnt, 2);
      checkOutput("t5_ends", end_cnt, 1);
      checkOutput("t5_rises", rise_cnt, 1);
      checkOutput("t5_busy_after", int'(bus.o_busy), 0);
      bus.i_en = 1'b0;
      runCycles(2);
      bus.i_en = 1'b1;
      clearCounters();
      runCycles(10);
      checkOutput("t5_retrig_high", high_cnt, 2);
      checkOutput("t5_retrig_ends", end_cnt, 1);
      bus.i_en = 1'b0;
      bus.i_oneshot = 1'b0;
      runCycles(3);

      $display("[TB] period=0 boundary");
      applyStimulus(1'b1, 1'b0, 1, 0, 1);
      clearCounters();
      runCycles(20);
      checkOutput("t7_ends", end_cnt, 9);
      checkOutput("t7_high", high_cnt, 20);
      bus.i_en = 1'b0;
      waitIdle();

      $display("[TB] en drop mid-period");
      applyStimulus(1'b1, 1'b0, 0, 9, 3);
      waitCnt(2);
      bus.i_en = 1'b0;
      clearCounters();
      waitEnd(cycles);
      checkOutput("t6_cycles_to_end", cycles, 8);
      checkOutput("t6_maxcnt", max_cnt, 9);
      checkOutput("t6_busy_after", int'(bus.o_busy), 0);
      runCycles(2);

      $display("[TB] async reset mid-pulse");
      applyStimulus(1'b1, 1'b0, 0, 9, 3);
      waitCnt(1);
      checkOutput("t8_pulse_before_reset", int'(bus.o_pulse), 1);
      #2;
      i_rst_n = 1'b0;
      #1;
      checkAllZero("t8_async");
      step();
      bus.i_en = 1'b0;
      i_rst_n  = 1'b1;
      runCycles(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
      $finish;
   end

endmodule
